// File: rtl/spi_cmd_ram.sv
// rtl/spi_cmd_ram.sv - command-driven word RAM with a valid/ready read-data port
// Optional feature macro: SPI_CMD_RAM_AUTOINC_EN (post-access address auto-increment with wrap)
module spi_cmd_ram #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              busy,
    output logic              cmd_err
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        TX_HOLD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_dout;
    logic              r_tx_valid;
    logic              r_cmd_err;

    logic [1:0]        w_op;
    logic [DATA_W-1:0] w_payload;
    logic              w_accept;
    logic              w_drop;
    logic              w_addr_ok;
    logic              w_set_wa;
    logic              w_set_ra;
    logic              w_bad_addr;
    logic              w_write;
    logic              w_read_cmd;
    logic              w_pend;
    logic              w_release;

    assign w_op       = din[DATA_W+1:DATA_W];
    assign w_payload  = din[DATA_W-1:0];
    // A command slot opens in IDLE, or in TX_HOLD on the cycle the consumer takes the data
    assign w_accept   = rx_valid && ((r_state == IDLE) || ((r_state == TX_HOLD) && tx_ready));
    assign w_drop     = rx_valid && !w_accept;
    assign w_addr_ok  = ({1'b0, w_payload} < (DATA_W+1)'(MEM_DEPTH));
    assign w_set_wa   = w_accept && (w_op == 2'b00) && w_addr_ok;
    assign w_set_ra   = w_accept && (w_op == 2'b10) && w_addr_ok;
    assign w_bad_addr = w_accept && !w_op[0] && !w_addr_ok;
    assign w_write    = w_accept && (w_op == 2'b01);
    assign w_read_cmd = w_accept && (w_op == 2'b11);
    assign w_pend     = (r_state == RD_PEND);
    assign w_release  = (r_state == TX_HOLD) && tx_ready;

`ifdef SPI_CMD_RAM_AUTOINC_EN
    function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_read_cmd) w_next_state = RD_PEND;
            RD_PEND: w_next_state = TX_HOLD;
            TX_HOLD: if (tx_ready) w_next_state = w_read_cmd ? RD_PEND : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Storage is deliberately outside the reset domain so contents survive rst
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_mem[r_wr_addr] <= w_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_dout     <= '0;
            r_tx_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= w_drop || w_bad_addr;

            if (w_set_wa) begin
                r_wr_addr <= w_payload[ADDR_W-1:0];
            end
`ifdef SPI_CMD_RAM_AUTOINC_EN
            else if (w_write) begin
                r_wr_addr <= f_inc(r_wr_addr);
            end
`endif

            if (w_set_ra) begin
                r_rd_addr <= w_payload[ADDR_W-1:0];
            end
`ifdef SPI_CMD_RAM_AUTOINC_EN
            else if (w_pend) begin
                r_rd_addr <= f_inc(r_rd_addr);
            end
`endif

            if (w_pend) begin
                r_dout     <= r_mem[r_rd_addr];
                r_tx_valid <= 1'b1;
            end else if (w_release) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign busy     = (r_state != IDLE);
    assign cmd_err  = r_cmd_err;

endmodule
